// File: rtl/alu_datapath_if.sv
// Strobe and observation bundle between the ALU sequencing FSM and the shared-bus datapath.
// The FSM side uses the master modport and the datapath uses the slave modport.
interface alu_datapath_if #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PCW   = 8
);
  logic [15:0]      fullBitNum;
  logic             G0_in, G1_in, G2_in, G3_in;
  logic             G0_out, G1_out, G2_out, G3_out;
  logic             ALUin1, ALUin2;
  logic             ALU_outlach, ALU_outEN;
  logic             ext_en;
  logic [WIDTH-1:0] ext_data;
  logic             PC_inc;
  logic             done;
  logic             err_clr;
  logic [1:0]       dbg_sel;

  logic [WIDTH-1:0] bus;
  logic [PCW-1:0]   pc;
  logic             flag_z, flag_c, flag_n;
  logic             bus_err;
  logic [7:0]       retired;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output fullBitNum, G0_in, G1_in, G2_in, G3_in, G0_out, G1_out, G2_out, G3_out,
           ALUin1, ALUin2, ALU_outlach, ALU_outEN, ext_en, ext_data, PC_inc, done,
           err_clr, dbg_sel,
    input  bus, pc, flag_z, flag_c, flag_n, bus_err, retired, dbg_data
  );

  modport slave (
    input  fullBitNum, G0_in, G1_in, G2_in, G3_in, G0_out, G1_out, G2_out, G3_out,
           ALUin1, ALUin2, ALU_outlach, ALU_outEN, ext_en, ext_data, PC_inc, done,
           err_clr, dbg_sel,
    output bus, pc, flag_z, flag_c, flag_n, bus_err, retired, dbg_data
  );
endinterface

// File: rtl/alu_datapath.sv
// Shared-bus datapath: general registers G0-G3, ALU operand/result latches, PC, flags,
// contention detection and a saturating retired-instruction counter.
module alu_datapath #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned PCW   = 8
) (
  input logic           clk,
  input logic           rst,
  alu_datapath_if.slave dp
);

  localparam int unsigned NDrv = 6;

  logic [WIDTH-1:0] g_q [4];
  logic [WIDTH-1:0] a_q, b_q, r_q;
  logic [PCW-1:0]   pc_q;
  logic             flag_z_q, flag_c_q, flag_n_q;
  logic             bus_err_q;
  logic [7:0]       retired_q;

  logic [NDrv-1:0]  drv;
  logic             contention;
  logic [3:0]       g_out, g_in;
  logic [WIDTH-1:0] bus_val;

  assign g_out = {dp.G3_out, dp.G2_out, dp.G1_out, dp.G0_out};
  assign g_in  = {dp.G3_in, dp.G2_in, dp.G1_in, dp.G0_in};
  assign drv   = {g_out, dp.ALU_outEN, dp.ext_en};

  // More than one bit set in the driver vector means contention.
  assign contention = (drv & (drv - NDrv'(1))) != '0;

  always_comb begin
    bus_val = '0;
    if (!contention) begin
      for (int i = 0; i < 4; i++) begin
        if (g_out[i]) bus_val = bus_val | g_q[i];
      end
      if (dp.ALU_outEN) bus_val = bus_val | r_q;
      if (dp.ext_en)    bus_val = bus_val | dp.ext_data;
    end
  end

  logic [3:0]       opcode;
  logic [3:0]       shamt;
  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] alu_r;
  logic             alu_c;
  logic             alu_valid;

  assign opcode = dp.fullBitNum[15:12];
  assign shamt  = b_q[3:0];

  // The extra bit of 'wide' holds carry, borrow or the last bit shifted out.
  always_comb begin
    wide      = '0;
    alu_r     = r_q;
    alu_c     = 1'b0;
    alu_valid = 1'b1;
    case (opcode)
      4'b1001: begin
        wide  = {1'b0, a_q} + {1'b0, b_q};
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      4'b1010: begin
        wide  = {1'b0, a_q} - {1'b0, b_q};
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      4'b1011: alu_r = a_q & b_q;
      4'b1100: alu_r = a_q | b_q;
      4'b1101: alu_r = a_q ^ b_q;
      4'b1110: begin
        wide  = {1'b0, a_q} << shamt;
        alu_r = wide[WIDTH-1:0];
        alu_c = wide[WIDTH];
      end
      4'b1111: begin
        wide  = {a_q, 1'b0} >> shamt;
        alu_r = wide[WIDTH:1];
        alu_c = wide[0];
      end
      default: alu_valid = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) g_q[i] <= '0;
      a_q       <= '0;
      b_q       <= '0;
      r_q       <= '0;
      pc_q      <= '0;
      flag_z_q  <= 1'b0;
      flag_c_q  <= 1'b0;
      flag_n_q  <= 1'b0;
      bus_err_q <= 1'b0;
      retired_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (g_in[i]) g_q[i] <= bus_val;
      end
      if (dp.ALUin1) a_q <= bus_val;
      if (dp.ALUin2) b_q <= bus_val;
      if (dp.ALU_outlach && alu_valid) begin
        r_q      <= alu_r;
        flag_z_q <= (alu_r == '0);
        flag_c_q <= alu_c;
        flag_n_q <= alu_r[WIDTH-1];
      end
      if (dp.PC_inc) pc_q <= pc_q + PCW'(1);
      if (dp.done && (retired_q != 8'hFF)) retired_q <= retired_q + 8'd1;
      if (contention)      bus_err_q <= 1'b1;
      else if (dp.err_clr) bus_err_q <= 1'b0;
    end
  end

  assign dp.bus      = bus_val;
  assign dp.pc       = pc_q;
  assign dp.flag_z   = flag_z_q;
  assign dp.flag_c   = flag_c_q;
  assign dp.flag_n   = flag_n_q;
  assign dp.bus_err  = bus_err_q;
  assign dp.retired  = retired_q;
  assign dp.dbg_data = g_q[dp.dbg_sel];

endmodule

// File: tb/tb_alu_datapath.sv
// Directed bench for alu_datapath: a behavioural model checked every cycle, plus
// hand-computed literal expectations along the FSM-style sequences.
module tb_alu_datapath;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  alu_datapath_if #(.WIDTH(16), .PCW(8)) dp ();

  alu_datapath #(.WIDTH(16), .PCW(8)) dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp)
  );

  int unsigned total = 0;
  int unsigned bad   = 0;
  bit          chk_en = 1'b0;

  // Model state
  int unsigned mg [4];
  int unsigned ma, mb, mr, mpc, mret;
  bit          mz, mc, mn, merr;

  task automatic check(input string name, input int unsigned act, input int unsigned exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned drivers();
    int unsigned n = 0;
    if (dp.G0_out) n++;
    if (dp.G1_out) n++;
    if (dp.G2_out) n++;
    if (dp.G3_out) n++;
    if (dp.ALU_outEN) n++;
    if (dp.ext_en) n++;
    return n;
  endfunction

  function automatic int unsigned model_bus();
    if (drivers() != 1) return 0;
    if (dp.G0_out) return mg[0];
    if (dp.G1_out) return mg[1];
    if (dp.G2_out) return mg[2];
    if (dp.G3_out) return mg[3];
    if (dp.ALU_outEN) return mr;
    return int'(dp.ext_data);
  endfunction

  // Arithmetic on plain integers; carry derived from the numeric result, not bit slices.
  task automatic model_alu(input int unsigned op, input int unsigned a, input int unsigned b,
                           output int unsigned r, output bit c, output bit valid);
    int unsigned s;
    s     = b % 16;
    valid = 1'b1;
    c     = 1'b0;
    r     = 0;
    case (op)
      9:  begin r = (a + b) % 65536; c = (a + b) > 65535; end
      10: begin r = (a + 65536 - b) % 65536; c = a < b; end
      11: r = a & b;
      12: r = a | b;
      13: r = a ^ b;
      14: begin r = (a * (1 << s)) % 65536; c = (s != 0) && (((a >> (16 - s)) % 2) == 1); end
      15: begin r = a >> s; c = (s != 0) && (((a >> (s - 1)) % 2) == 1); end
      default: valid = 1'b0;
    endcase
  endtask

  always @(posedge clk) begin
    int unsigned bv, r;
    bit c, v;
    if (!rst) begin
      for (int i = 0; i < 4; i++) mg[i] = 0;
      ma = 0; mb = 0; mr = 0; mpc = 0; mret = 0;
      mz = 0; mc = 0; mn = 0; merr = 0;
    end else begin
      bv = model_bus();
      model_alu(int'(dp.fullBitNum[15:12]), ma, mb, r, c, v);
      if (dp.ALU_outlach && v) begin
        mr = r; mc = c; mz = (r == 0); mn = (r >= 32768);
      end
      if (dp.G0_in) mg[0] = bv;
      if (dp.G1_in) mg[1] = bv;
      if (dp.G2_in) mg[2] = bv;
      if (dp.G3_in) mg[3] = bv;
      if (dp.ALUin1) ma = bv;
      if (dp.ALUin2) mb = bv;
      if (dp.PC_inc) mpc = (mpc + 1) % 256;
      if (dp.done && mret < 255) mret++;
      if (drivers() > 1) merr = 1;
      else if (dp.err_clr) merr = 0;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("bus", int'(dp.bus), model_bus());
      check("pc", int'(dp.pc), mpc);
      check("flag_z", int'(dp.flag_z), int'(mz));
      check("flag_c", int'(dp.flag_c), int'(mc));
      check("flag_n", int'(dp.flag_n), int'(mn));
      check("bus_err", int'(dp.bus_err), int'(merr));
      check("retired", int'(dp.retired), mret);
      check("dbg_data", int'(dp.dbg_data), mg[dp.dbg_sel]);
    end
  end

  task automatic clr();
    {dp.G0_in, dp.G1_in, dp.G2_in, dp.G3_in} = '0;
    {dp.G0_out, dp.G1_out, dp.G2_out, dp.G3_out} = '0;
    {dp.ALUin1, dp.ALUin2, dp.ALU_outlach, dp.ALU_outEN} = '0;
    {dp.ext_en, dp.PC_inc, dp.done, dp.err_clr} = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    clr();
  endtask

  task automatic load_ext_a(input logic [15:0] v);
    dp.ext_data = v; dp.ext_en = 1'b1; dp.ALUin1 = 1'b1; step();
  endtask

  task automatic load_ext_b(input logic [15:0] v);
    dp.ext_data = v; dp.ext_en = 1'b1; dp.ALUin2 = 1'b1; step();
  endtask

  task automatic latch_and_show(input logic [3:0] op);
    dp.fullBitNum = {op, 12'h000};
    dp.ALU_outlach = 1'b1; step();
    dp.ALU_outEN = 1'b1; #1;
  endtask

  initial begin
    clr();
    dp.fullBitNum = '0;
    dp.ext_data   = '0;
    dp.dbg_sel    = 2'd0;

    // Reset with every strobe high
    repeat (2) begin
      {dp.G0_in, dp.G1_in, dp.G2_in, dp.G3_in, dp.G0_out, dp.G1_out, dp.G2_out} = '1;
      {dp.G3_out, dp.ALUin1, dp.ALUin2, dp.ALU_outlach, dp.ALU_outEN} = '1;
      {dp.ext_en, dp.PC_inc, dp.done, dp.err_clr} = '1;
      dp.ext_data = 16'hFFFF;
      dp.fullBitNum = 16'h9000;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    clr();
    chk_en = 1'b1;
    #1;
    check("rst_pc", int'(dp.pc), 0);
    check("rst_bus_err", int'(dp.bus_err), 0);
    check("rst_retired", int'(dp.retired), 0);
    check("rst_flags", int'({dp.flag_z, dp.flag_c, dp.flag_n}), 0);
    check("rst_bus", int'(dp.bus), 0);
    for (int i = 0; i < 4; i++) begin
      dp.dbg_sel = 2'(i); #1;
      check("rst_g", int'(dp.dbg_data), 0);
    end
    dp.dbg_sel = 2'd0;

    // ADD path
    dp.ext_data = 16'h7FFF; dp.ext_en = 1'b1; dp.G0_in = 1'b1; step();
    dp.ext_data = 16'h0001; dp.ext_en = 1'b1; dp.G1_in = 1'b1; step();
    dp.fullBitNum = 16'h9000;
    dp.G0_out = 1'b1; dp.ALUin1 = 1'b1; step();
    dp.G1_out = 1'b1; dp.ALUin2 = 1'b1; step();
    dp.ALU_outlach = 1'b1; step();
    dp.ALU_outEN = 1'b1; dp.G0_in = 1'b1; step();
    check("add_g0", int'(dp.dbg_data), 32'h8000);
    check("add_flags_zcn", int'({dp.flag_z, dp.flag_c, dp.flag_n}), 32'b001);

    // SUB with borrow, then equal operands
    load_ext_a(16'h0003);
    load_ext_b(16'h0005);
    latch_and_show(4'b1010);
    check("sub_r", int'(dp.bus), 32'hFFFE);
    check("sub_c_n", int'({dp.flag_c, dp.flag_n}), 32'b11);
    step();
    load_ext_a(16'h0005);
    latch_and_show(4'b1010);
    check("sub_eq_r", int'(dp.bus), 0);
    check("sub_eq_z_c", int'({dp.flag_z, dp.flag_c}), 32'b10);
    step();

    // Shifts and an invalid opcode
    load_ext_a(16'h8001);
    load_ext_b(16'h0001);
    latch_and_show(4'b1110);
    check("shl_r", int'(dp.bus), 32'h0002);
    check("shl_c", int'(dp.flag_c), 1);
    step();
    load_ext_b(16'h0000);
    latch_and_show(4'b1111);
    check("shr_r", int'(dp.bus), 32'h8001);
    check("shr_c", int'(dp.flag_c), 0);
    step();
    load_ext_b(16'h0004);
    latch_and_show(4'b0011);
    check("nop_r", int'(dp.bus), 32'h8001);
    check("nop_flags_zcn", int'({dp.flag_z, dp.flag_c, dp.flag_n}), 32'b001);
    step();

    // Latch with simultaneous operand load: op uses old A (0x8001) and B (4)
    dp.fullBitNum = 16'hB000;
    dp.ext_data = 16'h00FF; dp.ext_en = 1'b1; dp.ALUin1 = 1'b1; dp.ALU_outlach = 1'b1; step();
    dp.ALU_outEN = 1'b1; #1;
    check("and_old_ab", int'(dp.bus), 0);
    step();

    // Contention
    dp.ext_data = 16'h1234; dp.ext_en = 1'b1; dp.G3_in = 1'b1; step();
    dp.ext_data = 16'h5555; dp.ext_en = 1'b1; dp.G2_in = 1'b1; step();
    dp.G0_out = 1'b1; dp.G2_out = 1'b1; dp.G3_in = 1'b1; #1;
    check("cont_bus", int'(dp.bus), 0);
    step();
    dp.dbg_sel = 2'd3; #1;
    check("cont_g3", int'(dp.dbg_data), 0);
    check("cont_err", int'(dp.bus_err), 1);
    dp.G1_out = 1'b1; dp.ext_en = 1'b1; dp.err_clr = 1'b1; step();
    check("cont_err_clr_race", int'(dp.bus_err), 1);
    dp.err_clr = 1'b1; step();
    check("err_clr", int'(dp.bus_err), 0);

    // PC wrap
    for (int i = 0; i < 255; i++) begin
      dp.PC_inc = 1'b1; step();
    end
    check("pc_ff", int'(dp.pc), 32'hFF);
    dp.PC_inc = 1'b1; step();
    check("pc_wrap", int'(dp.pc), 0);

    // Retired saturation
    for (int i = 0; i < 300; i++) begin
      dp.done = 1'b1; step();
    end
    check("retired_sat", int'(dp.retired), 255);

    // Reset mid-sequence clears pending operands
    dp.dbg_sel = 2'd0;
    load_ext_a(16'h0005);
    load_ext_b(16'h0007);
    chk_en = 1'b0;
    rst = 1'b0; dp.ALU_outlach = 1'b1; dp.fullBitNum = 16'h9000; step();
    rst = 1'b1;
    chk_en = 1'b1;
    latch_and_show(4'b1001);
    check("mid_rst_r", int'(dp.bus), 0);
    check("mid_rst_z", int'(dp.flag_z), 1);
    check("mid_rst_retired", int'(dp.retired), 0);
    step();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_datapath.md
# alu_datapath

Shared-bus datapath that responds to the control strobes issued by the ALU sequencing FSM. It holds the four general registers G0–G3, the ALU operand latches A and B, and the result latch R, and it arbitrates a single 16-bit internal bus. It also maintains the program counter and ALU status flags. It sits beside the ALU FSM in the microcontroller top level, consuming that FSM's `Gx_in`/`Gx_out`, `ALUin1`/`ALUin2`, `ALU_outlach`/`ALU_outEN`, `PC_inc` and `done` outputs, together with the same `fullBitNum` instruction word.

## Interface
- `WIDTH`, default 16: bus, register and ALU width.
- `PCW`, default 8: program counter width.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: synchronous, active-low reset.
- `fullBitNum` input 16: current instruction; `[15:12]` is the opcode.
- `G0_in`, `G1_in`, `G2_in`, `G3_in` input 1 each: load Gx from the bus.
- `G0_out`, `G1_out`, `G2_out`, `G3_out` input 1 each: Gx drives the bus.
- `ALUin1` input 1: load A from the bus.
- `ALUin2` input 1: load B from the bus.
- `ALU_outlach` input 1: compute op(A,B) and latch it into R, updating the flags.
- `ALU_outEN` input 1: R drives the bus.
- `ext_en` input 1: `ext_data` drives the bus (load path).
- `ext_data` input WIDTH: external bus source.
- `PC_inc` input 1: increment the PC.
- `done` input 1: instruction complete; increments the retired count.
- `err_clr` input 1: clear `bus_err`.
- `dbg_sel` input 2: selects G0..G3 onto `dbg_data`.
- `bus` output WIDTH: current internal bus value (combinational).
- `pc` output PCW: program counter.
- `flag_z`, `flag_c`, `flag_n` output 1 each: zero, carry/borrow and negative flags of R.
- `bus_err` output 1: sticky bus contention flag.
- `retired` output 8: count of completed instructions, saturating.
- `dbg_data` output WIDTH: the Gx register selected by `dbg_sel`.

## Operation
- **Bus drivers:** G0_out, G1_out, G2_out, G3_out, ALU_outEN and ext_en.
  - Exactly one driver asserted: `bus` equals that source.
  - No driver asserted: `bus` = 0.
  - Two or more drivers asserted: `bus` = 0 and `bus_err` is set on the next edge. The register loads in that cycle still occur and capture 0.
- **Loads:** every asserted `Gx_in`, `ALUin1` or `ALUin2` captures `bus` at the edge. Multiple loads in the same cycle are all performed.
- **ALU operation:** when `ALU_outlach` is asserted, the datapath decodes the opcode `fullBitNum[15:12]` in that same cycle and computes op(A,B). A and B are the values present before the edge.
  - 1001 ADD: R = A+B; c = carry out of the MSB.
  - 1010 SUB: R = A−B; c = 1 iff A < B (unsigned borrow).
  - 1011 AND, 1100 OR, 1101 XOR: c = 0.
  - 1110 SHL: R = A << B[3:0]; c = last bit shifted out; c = 0 when the shift amount is 0.
  - 1111 SHR (logical): R = A >> B[3:0]; same carry rule as SHL.
  - Opcode < 1001: R and the flags are left unchanged.
- **Flags:** z = (R_new == 0) and n = R_new[MSB]. Flags update only on a valid ALU_outlach.
- **ALU_outlach and ALUin1/ALUin2 together:** the op uses the old A/B, while A/B still load from the bus.
- **PC:** increments by 1 on `PC_inc` and wraps from all-ones to 0.
- **Retired count:** `retired` increments on `done` and saturates at 255.
- **bus_err:** set has priority over `err_clr` when both occur in the same cycle; `err_clr` alone clears it.
- **Reset:** reset (`rst`=0) overrides every other input. All registers, A, B, R, pc, the flags, `bus_err` and `retired` become 0.
- **dbg_data:** combinational view of the Gx register selected by `dbg_sel`.

## Timing
- `bus` and `dbg_data` are combinational, with zero-cycle latency from the strobes and `dbg_sel`.
- All state-holding outputs (`pc`, the flags, `bus_err`, `retired`) are visible in the cycle after the enabling strobe.
- Write-through in one cycle: `Gx_out` together with `ALUin1` moves a register into A in that cycle.
- `ALU_outEN` together with `Gy_in` moves R into Gy in that cycle.
- A register read in the same cycle it is written returns the old value on the bus.
- Full FSM sequence: op1 → A, op2 → B, latch R, write back. The result is visible in the destination Gx one cycle after the write-back strobe, and `retired` increments one cycle after `done`.
- Reset mid-sequence: state is cleared at that edge. Strobes arriving in later cycles act on the zeroed state; no pending operation is retained.

## Test plan
- **Reset:** hold `rst`=0 for 2 cycles with every strobe high. Required: all outputs are 0 afterwards and `bus_err` = 0.
- **ADD path:**
  - Setup: via `ext_en`, load G0 = 0x7FFF and G1 = 0x0001; opcode = 1001.
  - Sequence: G0_out+ALUin1, G1_out+ALUin2, ALU_outlach, ALU_outEN+G0_in.
  - Required: G0 = 0x8000, n = 1, z = 0, c = 0.
- **SUB borrow:** A = 0x0003, B = 0x0005, opcode 1010. Required: R = 0xFFFE, c = 1, n = 1. Repeat with A = B = 0x0005. Required: R = 0, z = 1, c = 0.
- **Shifts:**
  - SHL with A = 0x8001, B = 0x0001: R = 0x0002, c = 1.
  - SHR with A = 0x8001, B = 0x0000: R = 0x8001, c = 0.
  - Opcode 0011 with ALU_outlach: R and flags are unchanged.
- **Contention:**
  - G0_out and G2_out asserted together with G3_in: bus = 0, G3 = 0, bus_err = 1 next cycle.
  - err_clr together with a new contention: bus_err stays 1.
  - err_clr alone: bus_err = 0.
- **PC and retired counters:**
  - With PCW = 8, apply 256 PC_inc pulses: pc returns to 0x00.
  - Apply 300 done pulses: retired = 255.
